sipo_frame_rx: RTL and testbench

Serial-to-parallel frame receiver. It consumes the registered single-bit stream from the D flip-flop stage: bit `Q` feeds `din`. Each frame is a start bit, `DATA_W` data bits LSB-first, an optional parity bit and a stop bit. Valid words are presented on a valid/ready output register to the downstream parallel logic. Bits advance only on cycles where the `bit_en` strobe is high.

---
 rtl/sipo_rx_pkg.sv | 20 ++
 rtl/rx_out_buf.sv | 53 +++++
 rtl/sipo_frame_rx.sv | 121 ++++++++++++
 tb/tb_sipo_frame_rx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package sipo_rx_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int PARITY_EN_DEF  = 1;
    localparam int PARITY_ODD_DEF = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_w(input int dataW);
        return (dataW <= 2) ? 1 : $clog2(dataW);
    endfunction

endpackage

// File: rtl/rx_out_buf.sv
// Valid/ready holding register for received words, including the
// load / accept / overrun decision made when a good stop bit arrives.
module rx_out_buf
    import sipo_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_perr,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_valid,
    output logic              o_perr,
    output logic              o_overrun
);

    logic [DATA_W-1:0] r_dout;
    logic              r_valid;
    logic              r_perr;
    logic              r_overrun;
    logic              w_free;

    // The buffer can take a new word if empty or being drained this edge.
    assign w_free = !r_valid || i_ready;

    // Load a new word, retire an accepted one, or flag a dropped frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && !w_free;
            if (i_load && w_free) begin
                r_dout  <= i_data;
                r_perr  <= i_perr;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_dout    = r_dout;
    assign o_valid   = r_valid;
    assign o_perr    = r_perr;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, LSB-first data, optional
// parity, stop bit. Bits advance only on bit_en strobes.
module sipo_frame_rx
    import sipo_rx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PARITY_EN  = PARITY_EN_DEF,
    parameter int PARITY_ODD = PARITY_ODD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bit_en,
    input  logic              i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int              CNT_W    = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              r_xor;
    logic              w_xor_nxt;
    logic              r_perr;
    logic              w_perr_nxt;
    logic              r_frame_err;
    logic              w_stop_good;
    logic              w_stop_bad;

    // Frame state, bit counter, shift register and parity tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_xor       <= 1'b0;
            r_perr      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_xor       <= w_xor_nxt;
            r_perr      <= w_perr_nxt;
            r_frame_err <= w_stop_bad;
        end
    end

    // Next-state logic; everything holds unless a bit strobe arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_xor_nxt   = r_xor;
        w_perr_nxt  = r_perr;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        if (i_bit_en) begin
            case (r_state)
                IDLE: begin
                    if (!i_din) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = '0;
                        w_shift_nxt = '0;
                        w_xor_nxt   = 1'b0;
                        w_perr_nxt  = 1'b0;
                    end
                end
                DATA: begin
                    w_shift_nxt[r_cnt] = i_din;
                    w_xor_nxt          = r_xor ^ i_din;
                    if (r_cnt == LAST_BIT) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    w_perr_nxt  = r_xor ^ i_din ^ 1'(PARITY_ODD);
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    w_stop_good = i_din;
                    w_stop_bad  = !i_din;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    rx_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_stop_good),
        .i_data    (r_shift),
        .i_perr    (r_perr),
        .i_ready   (i_dout_ready),
        .o_dout    (o_dout),
        .o_valid   (o_dout_valid),
        .o_perr    (o_parity_err),
        .o_overrun (o_overrun)
    );

    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Scoreboard bench for sipo_frame_rx: instance 0 uses even parity,
// instance 1 has no parity bit. A frame-level model predicts words and
// error pulses; a negedge monitor compares whatever the DUTs present.
module tb_sipo_frame_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bitEn [2];
    logic         din   [2];
    logic         ready [2];
    logic [W-1:0] dout  [2];
    logic         valid [2];
    logic         perr  [2];
    logic         ferr  [2];
    logic         ovr   [2];
    logic         busy  [2];

    int checks = 0;
    int errors = 0;

    // Reference model state: buffer occupancy, frame collection, expectations.
    bit held    [2];
    bit inFrame [2];
    bit bitsQ   [2][$];
    int wordQ   [2][$];
    int evQ     [2][$];

    always #5 clk = ~clk;

    sipo_frame_rx #(.DATA_W(W), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_bit_en(bitEn[0]), .i_din(din[0]),
        .o_dout(dout[0]), .o_dout_valid(valid[0]), .i_dout_ready(ready[0]),
        .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_overrun(ovr[0]),
        .o_busy(busy[0])
    );

    sipo_frame_rx #(.DATA_W(W), .PARITY_EN(0), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_bit_en(bitEn[1]), .i_din(din[1]),
        .o_dout(dout[1]), .o_dout_valid(valid[1]), .i_dout_ready(ready[1]),
        .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_overrun(ovr[1]),
        .o_busy(busy[1])
    );

    function automatic int parityEn(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            held[k]    = 1'b0;
            inFrame[k] = 1'b0;
            bitsQ[k].delete();
            wordQ[k].delete();
            evQ[k].delete();
        end
    endtask

    // Frame-level model of one edge: collect bits, judge the frame at its end.
    task automatic modelStep(input int k);
        bit free;
        int val;
        int ones;
        bit pb;
        bit pe;
        bit stopBit;
        free = !held[k] || ready[k];
        if (held[k] && ready[k]) held[k] = 1'b0;
        if (bitEn[k]) begin
            if (!inFrame[k]) begin
                if (!din[k]) begin
                    inFrame[k] = 1'b1;
                    bitsQ[k].delete();
                end
            end else begin
                bitsQ[k].push_back(din[k]);
                if (bitsQ[k].size() == W + parityEn(k) + 1) begin
                    val  = 0;
                    ones = 0;
                    for (int i = 0; i < W; i++) begin
                        val  = val + (int'(bitsQ[k][i]) << i);
                        ones = ones + int'(bitsQ[k][i]);
                    end
                    pb      = (parityEn(k) != 0) ? bitsQ[k][W] : 1'b0;
                    pe      = (parityEn(k) != 0) && (((ones + int'(pb)) % 2) != 0);
                    stopBit = bitsQ[k][bitsQ[k].size() - 1];
                    inFrame[k] = 1'b0;
                    if (!stopBit) begin
                        evQ[k].push_back(1);
                    end else if (free) begin
                        wordQ[k].push_back(val + (pe ? 65536 : 0));
                        held[k] = 1'b1;
                    end else begin
                        evQ[k].push_back(2);
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            modelStep(0);
            modelStep(1);
        end
    end

    task automatic popEvent(input int k, input int code, input string name);
        if (evQ[k].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s[%0d]: got unexpected pulse, expected none", name, k);
        end else begin
            checkOutput($sformatf("%s[%0d] kind", name, k), code, evQ[k][0]);
            void'(evQ[k].pop_front());
        end
    endtask

    task automatic monitorOne(input int k);
        int act;
        checkOutput($sformatf("busy[%0d]", k), int'(busy[k]), int'(inFrame[k]));
        checkOutput($sformatf("valid[%0d]", k), int'(valid[k]), int'(held[k]));
        if (valid[k]) begin
            act = int'(dout[k]) + (perr[k] ? 65536 : 0);
            if (wordQ[k].size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL word[%0d]: got 'h%0h, expected no word", k, act);
            end else begin
                checkOutput($sformatf("word[%0d]", k), act, wordQ[k][0]);
                if (ready[k]) void'(wordQ[k].pop_front());
            end
        end
        if (ferr[k]) popEvent(k, 1, "frame_err");
        if (ovr[k])  popEvent(k, 2, "overrun");
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) monitorOne(k);
    end

    task automatic tick(input int k, input bit en, input bit d, input bit r);
        bitEn[k]   = en;
        din[k]     = d;
        ready[k]   = r;
        bitEn[1-k] = 1'b0;
        din[1-k]   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) begin
            ready[1] = r;
            tick(0, 1'b0, 1'b1, r);
        end
    endtask

    // Serialise one frame; bit strobes every 'gap' cycles with junk in between.
    task automatic applyStimulus(input int k, input logic [W-1:0] data, input bit flipPar,
                                 input bit stopBit, input int gap, input bit rdy,
                                 input bit rdyAtStop);
        bit bl[$];
        bl.push_back(1'b0);
        for (int i = 0; i < W; i++) bl.push_back(data[i]);
        if (parityEn(k) != 0) bl.push_back((^data) ^ flipPar);
        bl.push_back(stopBit);
        for (int j = 0; j < bl.size(); j++) begin
            for (int g = 0; g < gap - 1; g++) tick(k, 1'b0, 1'($urandom_range(0, 1)), rdy);
            tick(k, 1'b1, bl[j], (j == bl.size() - 1) ? rdyAtStop : rdy);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            bitEn[k] = 1'b0;
            din[k]   = 1'b1;
            ready[k] = 1'b1;
        end
        resetModel();
        #2;
        checkOutput("reset dout", int'(dout[0]), 0);
        checkOutput("reset valid", int'(valid[0]), 0);
        checkOutput("reset busy", int'(busy[0]), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1'b1);

        // 0xA5 with correct even parity: one-cycle valid, no parity error.
        applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        checkOutput("A5 dout", int'(dout[0]), 'hA5);
        checkOutput("A5 valid", int'(valid[0]), 1);
        checkOutput("A5 perr", int'(perr[0]), 0);
        idle(1, 1'b1);
        checkOutput("A5 valid one cycle", int'(valid[0]), 0);

        // Same frame with a flipped parity bit is still delivered.
        applyStimulus(0, 8'hA5, 1'b1, 1'b1, 1, 1'b1, 1'b1);
        checkOutput("A5 bad parity dout", int'(dout[0]), 'hA5);
        checkOutput("A5 bad parity perr", int'(perr[0]), 1);
        idle(1, 1'b1);

        // Stop bit 0: frame error pulse, nothing delivered.
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        checkOutput("3C frame_err", int'(ferr[0]), 1);
        checkOutput("3C valid", int'(valid[0]), 0);
        checkOutput("3C busy", int'(busy[0]), 0);
        idle(1, 1'b1);
        checkOutput("3C frame_err one cycle", int'(ferr[0]), 0);

        // Consumer stalled: second back-to-back frame overruns.
        applyStimulus(0, 8'h11, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        applyStimulus(0, 8'h22, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        checkOutput("overrun pulse", int'(ovr[0]), 1);
        checkOutput("overrun held dout", int'(dout[0]), 'h11);
        idle(1, 1'b0);
        checkOutput("overrun one cycle", int'(ovr[0]), 0);
        idle(1, 1'b1);
        checkOutput("after drain valid", int'(valid[0]), 0);

        // No parity, strobe every 3rd cycle; accept and load on the same edge.
        applyStimulus(1, 8'h5A, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        applyStimulus(1, 8'h0F, 1'b0, 1'b1, 3, 1'b0, 1'b1);
        checkOutput("replace dout", int'(dout[1]), 'h0F);
        checkOutput("replace valid", int'(valid[1]), 1);
        idle(2, 1'b1);

        // Reset mid-frame while a word is held.
        applyStimulus(0, 8'h77, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        tick(0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(0, 1'b1, 1'(8'hC3 >> i), 1'b0);
        #2;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("midreset dout", int'(dout[0]), 0);
        checkOutput("midreset valid", int'(valid[0]), 0);
        checkOutput("midreset perr", int'(perr[0]), 0);
        checkOutput("midreset frame_err", int'(ferr[0]), 0);
        checkOutput("midreset overrun", int'(ovr[0]), 0);
        checkOutput("midreset busy", int'(busy[0]), 0);
        bitEn[0] = 1'b0;
        din[0]   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1, 1'b1);
        applyStimulus(0, 8'hC3, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        checkOutput("C3 dout", int'(dout[0]), 'hC3);
        checkOutput("C3 perr", int'(perr[0]), 0);

        // Randomised frames across both instances.
        for (int n = 0; n < 60; n++) begin
            int k;
            int idleCnt;
            bit rd;
            k = int'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            idleCnt = int'($urandom_range(0, 2));
            for (int i = 0; i < idleCnt; i++) tick(k, 1'b1, 1'b1, rd);
            applyStimulus(k, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 7) != 0), int'($urandom_range(1, 3)), rd,
                          1'($urandom_range(0, 1)));
        end

        idle(4, 1'b1);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("pending words[%0d]", k), wordQ[k].size(), 0);
            checkOutput($sformatf("pending events[%0d]", k), evQ[k].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
